output_deskew: RTL and testbench
================================

Name: output_deskew

Overview:
Result collector at the bottom edge of the N×N systolic array. It is the counterpart of the skewed activation feeder: that block staggers row inputs in time, and this block undoes the stagger on the column outputs.
Column j delivers result row i exactly LAT+i+j cycles after the start pulse. The block captures each element on its scheduled cycle, assembles the full N×N result matrix and presents it with a valid/ready handshake.
It sits between the array's psum outputs and the result writeback / host readout logic.

Parameters:
N, 2, array dimension (rows = columns of result matrix); N >= 2
DW, 16, width of one partial-sum/result element
LAT, 2, cycles from the start-sampled edge to element (0,0) on column 0; LAT >= 1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse, same cycle the activation feeder begins streaming
psum_in  input  N*DW  column outputs; column j at bits [j*DW +: DW]
res_out  output  N*N*DW  assembled matrix; element (i,j) at bits [(i*N+j)*DW +: DW]
res_valid  output  1  res_out complete and stable
res_ready  input  1  consumer accepts res_out when res_valid && res_ready
busy  output  1  high in COLLECT state
start_dropped  output  1  sticky; set when a start is ignored; cleared only by reset

Behaviour:
- Clock is clk; reset is asynchronous, active-high. Reset forces state IDLE, cnt=0, all res_out elements 0, res_valid=0, busy=0, start_dropped=0.
- Reset asserted mid-COLLECT or mid-HOLD aborts the operation. Partial results are discarded (zeroed); no res_valid pulse is produced.
- States: IDLE, COLLECT, HOLD. res_valid = (state==HOLD); busy = (state==COLLECT); both registered-state decodes with no combinational path from inputs.
- IDLE: start=1 -> COLLECT with cnt<=1. Otherwise remain.
- COLLECT: cnt increments by 1 each cycle; counter width is $clog2(LAT+2N)+1, so it never wraps.
  - At each cycle, for every column j and row i with cnt == LAT+i+j, capture res[i][j] <= psum_in[j]. One column may capture at most one element per cycle.
  - Elements not yet scheduled keep their prior value. They are not cleared at start; they are overwritten before res_valid rises.
  - When cnt == LAT+2N-2 (the last capture, element (N-1,N-1)), next state is HOLD.
- Latency: start sampled at edge 0 -> res_valid high from edge LAT+2N-1 onward.
- HOLD: res_out frozen. On res_ready=1 -> IDLE, and res_valid drops the next cycle.
- HOLD with res_ready=1 and start=1 in the same cycle: the handshake completes and the block goes directly to COLLECT with cnt<=1. This allows back-to-back matrices.
- start=1 in COLLECT, or in HOLD without res_ready, is ignored and sets start_dropped.
- psum_in is sampled only on scheduled cycles; its value at all other times is don't-care.
- No arithmetic on data; elements pass through bit-exact at DW width.

Decomposition:
- Shared package tpu_pkg holds:
  - typedef state_t {IDLE, COLLECT, HOLD}
  - the default DW localparam shared with the PE/array blocks
- Natural sub-module: deskew_column (one per column via generate). Parameters N, DW, LAT, COL. Inputs cnt, capture enable, psum column. Holds the N-entry column register and compares cnt == LAT+i+COL per row.
- The top level keeps the FSM, counter, handshake and output packing.
- Target size 150-250 lines total.

Test Plan:
- Basic (N=2, LAT=2): start at cycle 0. Drive col0=10 @cycle2, col0=30 @3, col1=20 @3, col1=40 @4, and 0xDEAD on all other cycles -> res_valid rises at cycle 5 with (0,0)=10, (0,1)=20, (1,0)=30, (1,1)=40.
- Backpressure: hold res_ready=0 for 6 cycles after res_valid -> res_out and res_valid stable throughout. Assert res_ready for 1 cycle -> res_valid=0 the following cycle and state IDLE.
- Back-to-back: in the HOLD cycle, assert res_ready=1 and start=1 together -> second matrix (5,6,7,8) captured with the same timing. res_valid rises again 5 cycles after that start; start_dropped stays 0.
- Dropped start: pulse start at cycle 2 of a COLLECT -> capture schedule unchanged, results correct, start_dropped=1 and remains 1 after completion.
- Reset mid-COLLECT: assert reset at cycle 3 -> res_out all 0, res_valid=0, busy=0 immediately (async). A new start after release gives correct results with no stale data.
- Parameter sweep N=3, LAT=1: element (i,j)=10*i+j driven at cycle 1+i+j -> res_valid at cycle 6 with all 9 elements correct.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU types: FSM state encoding and default datapath width.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    localparam int DW_DEF = 16;

endpackage

// File: rtl/deskew_column.sv
// One result column: captures row i when cnt reaches LAT+i+COL.
module deskew_column
    import tpu_pkg::*;
#(
    parameter int N   = 2,
    parameter int DW  = DW_DEF,
    parameter int LAT = 2,
    parameter int COL = 0,
    parameter int CW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CW-1:0]   cnt,
    input  logic            en,
    input  logic [DW-1:0]   psum,
    output logic [N*DW-1:0] col
);

    logic [DW-1:0] col_q [N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                col_q[i] <= '0;
            end
        end else if (en) begin
            // Each row has a distinct slot, so at most one hit per cycle.
            for (int i = 0; i < N; i++) begin
                if (cnt == CW'(LAT + i + COL)) begin
                    col_q[i] <= psum;
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign col[i*DW +: DW] = col_q[i];
    end

endmodule

// File: rtl/output_deskew.sv
// Collects skewed systolic column outputs into an N x N result matrix.
module output_deskew
    import tpu_pkg::*;
#(
    parameter int N   = 2,
    parameter int DW  = DW_DEF,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N*DW-1:0]   psum_in,
    output logic [N*N*DW-1:0] res_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              start_dropped
);

    localparam int CW   = $clog2(LAT + 2*N) + 1;
    localparam int LAST = LAT + 2*N - 2;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dropped;
    logic          cap_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dropped <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        cnt   <= CW'(1);
                    end
                end
                COLLECT: begin
                    cnt <= cnt + CW'(1);
                    if (start) dropped <= 1'b1;
                    if (cnt == CW'(LAST)) state <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        // Handshake plus start chains matrices back to back.
                        if (start) begin
                            state <= COLLECT;
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (start) begin
                        dropped <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cap_en        = (state == COLLECT);
    assign res_valid     = (state == HOLD);
    assign busy          = (state == COLLECT);
    assign start_dropped = dropped;

    for (genvar j = 0; j < N; j++) begin : g_col
        logic [N*DW-1:0] col;

        deskew_column #(
            .N   (N),
            .DW  (DW),
            .LAT (LAT),
            .COL (j),
            .CW  (CW)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .cnt   (cnt),
            .en    (cap_en),
            .psum  (psum_in[j*DW +: DW]),
            .col   (col)
        );

        for (genvar i = 0; i < N; i++) begin : g_row
            assign res_out[(i*N+j)*DW +: DW] = col[i*DW +: DW];
        end
    end

endmodule

// File: tb/tb_output_deskew.sv
// Directed bench: N=2/LAT=2 and N=3/LAT=1 instances with fixed schedules.
module tb_output_deskew;

    logic          clk = 1'b0;
    logic          reset = 1'b1;

    logic          start2 = 1'b0;
    logic          ready2 = 1'b0;
    logic [31:0]   psum2 = '0;
    logic [63:0]   res2;
    logic          valid2, busy2, drop2;

    logic          start3 = 1'b0;
    logic          ready3 = 1'b0;
    logic [47:0]   psum3 = '0;
    logic [143:0]  res3;
    logic          valid3, busy3, drop3;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] DEAD = 16'hDEAD;

    always #5 clk = ~clk;

    output_deskew #(.N(2), .DW(16), .LAT(2)) u_dut2 (
        .clk           (clk),
        .reset         (reset),
        .start         (start2),
        .psum_in       (psum2),
        .res_out       (res2),
        .res_valid     (valid2),
        .res_ready     (ready2),
        .busy          (busy2),
        .start_dropped (drop2)
    );

    output_deskew #(.N(3), .DW(16), .LAT(1)) u_dut3 (
        .clk           (clk),
        .reset         (reset),
        .start         (start3),
        .psum_in       (psum3),
        .res_out       (res3),
        .res_valid     (valid3),
        .res_ready     (ready3),
        .busy          (busy3),
        .start_dropped (drop3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] el2(input int i, input int j);
        return res2[(i*2+j)*16 +: 16];
    endfunction

    function automatic logic [15:0] el3(input int i, input int j);
        return res3[(i*3+j)*16 +: 16];
    endfunction

    task automatic mat2(input string tag, input logic [15:0] e00,
                        input logic [15:0] e01, input logic [15:0] e10,
                        input logic [15:0] e11);
        chk({tag, "_valid"}, 32'(valid2), 32'd1);
        chk({tag, "_busy"}, 32'(busy2), 32'd0);
        chk({tag, "_00"}, 32'(el2(0, 0)), 32'(e00));
        chk({tag, "_01"}, 32'(el2(0, 1)), 32'(e01));
        chk({tag, "_10"}, 32'(el2(1, 0)), 32'(e10));
        chk({tag, "_11"}, 32'(el2(1, 1)), 32'(e11));
    endtask

    // Caller sets start/ready in cycle 0; returns in cycle 5 (HOLD).
    task automatic run2(input logic [15:0] e00, input logic [15:0] e01,
                        input logic [15:0] e10, input logic [15:0] e11,
                        input bit drop);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ready2 = 1'b0;
        chk("c1_busy", 32'(busy2), 32'd1);
        chk("c1_valid", 32'(valid2), 32'd0);
        psum2 = {DEAD, DEAD};
        tick();
        psum2 = {DEAD, e00};
        start2 = drop;
        tick();
        start2 = 1'b0;
        psum2 = {e01, e10};
        tick();
        psum2 = {e11, DEAD};
        chk("c4_valid", 32'(valid2), 32'd0);
        tick();
        psum2 = {DEAD, DEAD};
    endtask

    initial begin
        psum2 = {DEAD, DEAD};
        #12;
        chk("rst_valid", 32'(valid2), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_drop", 32'(drop2), 32'd0);
        chk("rst_res_lo", res2[31:0], 32'd0);
        chk("rst_res_hi", res2[63:32], 32'd0);
        reset = 1'b0;
        tick();

        // Basic capture
        run2(16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
        mat2("basic", 16'd10, 16'd20, 16'd30, 16'd40);

        // Backpressure: frozen while ready is low
        for (int k = 0; k < 6; k++) begin
            tick();
            mat2("hold", 16'd10, 16'd20, 16'd30, 16'd40);
        end
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        chk("rel_valid", 32'(valid2), 32'd0);
        chk("rel_busy", 32'(busy2), 32'd0);
        tick();
        chk("idle_busy", 32'(busy2), 32'd0);

        // Back-to-back: ready and start in the same HOLD cycle
        run2(16'd11, 16'd22, 16'd33, 16'd44, 1'b0);
        mat2("b2b_a", 16'd11, 16'd22, 16'd33, 16'd44);
        ready2 = 1'b1;
        run2(16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
        mat2("b2b_b", 16'd5, 16'd6, 16'd7, 16'd8);
        chk("b2b_drop", 32'(drop2), 32'd0);
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;

        // Dropped start during COLLECT
        run2(16'h100, 16'h200, 16'h300, 16'h400, 1'b1);
        mat2("drop", 16'h100, 16'h200, 16'h300, 16'h400);
        chk("drop_flag", 32'(drop2), 32'd1);
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        tick();
        chk("drop_sticky", 32'(drop2), 32'd1);
        chk("drop_idle", 32'(valid2), 32'd0);

        // Reset mid-COLLECT
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        psum2 = {DEAD, 16'h77};
        tick();
        reset = 1'b1;
        #1;
        chk("mrst_res_lo", res2[31:0], 32'd0);
        chk("mrst_res_hi", res2[63:32], 32'd0);
        chk("mrst_valid", 32'(valid2), 32'd0);
        chk("mrst_busy", 32'(busy2), 32'd0);
        chk("mrst_drop", 32'(drop2), 32'd0);
        #2;
        reset = 1'b0;
        psum2 = {DEAD, DEAD};
        tick();
        tick();
        chk("mrst_idle", 32'(busy2), 32'd0);
        run2(16'hA, 16'hB, 16'hC, 16'hD, 1'b0);
        mat2("post_rst", 16'hA, 16'hB, 16'hC, 16'hD);
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;

        // N=3, LAT=1: (i,j)=10*i+j arrives at cycle 1+i+j
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            for (int j = 0; j < 3; j++) begin
                int i;
                i = c - 1 - j;
                if (i >= 0 && i < 3) psum3[j*16 +: 16] = 16'(10*i + j);
                else psum3[j*16 +: 16] = DEAD;
            end
            if (c == 5) chk("n3_c5_valid", 32'(valid3), 32'd0);
            tick();
        end
        psum3 = {DEAD, DEAD, DEAD};
        chk("n3_valid", 32'(valid3), 32'd1);
        chk("n3_busy", 32'(busy3), 32'd0);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("n3_%0d%0d", i, j), 32'(el3(i, j)),
                    32'(10*i + j));
            end
        end
        chk("n3_drop", 32'(drop3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
